line_arb: RTL and testbench
===========================

Name: line_arb

Overview:
- Arbitrates the single qspi line-transfer engine between three requesters: instruction-cache fill, data-cache writeback/fill, and an auxiliary bulk port (boot loader / DMA).
- Sequences each transfer as grant, qspi request, wait for qspi completion, then completion pulse back to the owner.
- Computes the qspi memory/chip-select code from rom_mode, replacing the combinational req/mem/paddr muxing in the top level.

Parameters:
PA, 24, physical address width
LINE_LENGTH, 4, cache line length in bytes
TW, PA-$clog2(LINE_LENGTH), line tag width (derived, not overridable)

Ports:
clk  in  1  clock
reset  in  1  synchronous active-high reset
rom_mode  in  2  boot/ROM mapping mode from qspi config register
i_req  in  1  icache needs line fill
i_tag  in  TW  icache fill tag
i_done  out  1  one-cycle pulse: icache transfer complete
d_req  in  1  dcache needs line transfer
d_write  in  1  1=writeback (push), 0=fill (pull)
d_tag  in  TW  dcache line tag
d_done  out  1  one-cycle pulse: dcache transfer complete
x_req  in  1  aux port transfer request
x_write  in  1  aux direction, 1=write
x_tag  in  TW  aux line tag
x_done  out  1  one-cycle pulse: aux transfer complete
gnt  out  3  one-hot current owner {x,d,i}
q_req  out  1  request to qspi engine
q_i_d  out  1  1=instruction fetch transfer
q_write  out  1  transfer is a write
q_mem  out  2  qspi device select
q_paddr  out  TW  line tag to qspi
q_done  in  1  qspi transfer finished (single-cycle pulse)

Behaviour:
- Interface: one clock, clk. Reset is synchronous and active-high on reset.
- Reset values: state=IDLE; gnt=0; q_req=0; q_i_d=0; q_write=0; q_mem=0; q_paddr=0; all *_done=0; rr_ptr=i; d_follow=0.
- States:
  - IDLE: if any req, latch winner, go BUSY.
  - BUSY: q_req=1; wait for q_done.
  - DONE: pulse owner done; q_req=0; gnt cleared; go IDLE.
- Cycle timing:
  - req seen high in IDLE at cycle N: gnt, q_req and q_* valid at N+1.
  - q_done at cycle M: owner's done=1 and q_req=0 at M+1.
  - Next grant earliest at M+2.
  - Minimum transfer turnaround is 3 cycles of arbiter overhead.
- Arbitration in IDLE:
  - If d_follow=1 and d_req, grant d.
  - Otherwise round-robin starting at rr_ptr, order i->d->x->i.
  - rr_ptr advances to the position after the winner.
  - d_follow is set when a d write (push) completes, cleared on the next grant. This guarantees fill-after-writeback with no intervening transfer.
- Latched at grant, held stable through BUSY:
  - q_paddr = winner tag; q_write = winner write (0 for i); q_i_d = gnt[0].
  - q_mem, with msb = tag[TW-1]:
    - rom_mode 00: msb?2:0
    - rom_mode 01: 0
    - rom_mode 10: msb?1:0
    - rom_mode 11: (q_i_d | ~q_write)?1:0
- Requester rules:
  - Requester must hold req/tag/write stable until its done.
  - Deassertion while granted does not abort: the qspi transfer runs to completion and done still pulses.
  - Req held high after done is treated as a new request.
- q_done outside BUSY is ignored.
- Simultaneous requests: exactly one gnt bit is ever set; losers are served in round-robin order, and no requester waits more than 2 other transfers (plus one d_follow).
- Reset mid-transfer: returns to IDLE next cycle with all outputs 0. qspi shares the reset, so no stale q_done is expected.
- rom_mode changes during BUSY do not affect q_mem until the next grant.

Decomposition:
- Shared package: state encoding (IDLE/BUSY/DONE), requester index constants (I=0, D=1, X=2), q_mem codes (FLASH=0, PSRAM0=1, PSRAM1=2).
- One natural sub-module: rr_pick3. It is combinational: takes req[2:0], rr_ptr and d_follow, and returns a one-hot winner. This allows fairness to be verified standalone.

Test Plan:
- i_req only, i_tag=0x00_1234>>2, rom_mode=00 -> gnt=001 and q_req=1 next cycle, q_mem=0, q_i_d=1; q_done at +5 -> i_done pulse at +6, q_req=0.
- d_req/d_write=1 tag msb=1, rom_mode=00 -> q_mem=2, q_write=1; then d_req/d_write=0 raised together with i_req on d_done -> d granted first (d_follow), then i.
- i,d,x all held high, 6 transfers -> grant order i,d,x,i,d,x; gnt always one-hot.
- rom_mode=11: x write -> q_mem=0; x read -> q_mem=1; i fill -> q_mem=1; rom_mode toggled mid-BUSY -> q_mem unchanged.
- reset asserted during BUSY -> next cycle gnt=0, q_req=0, no done pulse; a stray q_done in IDLE produces no done.
- i_req dropped mid-BUSY -> transfer continues, i_done still pulses on q_done+1.

Source files
------------

// File: rtl/line_arb_pkg.sv
// Shared definitions for the qspi line-transfer arbiter: FSM states,
// requester indices, qspi device-select codes and the device-select rule.
package line_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Requester positions in req/gnt vectors and the round-robin pointer
  localparam logic [1:0] REQ_I = 2'd0;
  localparam logic [1:0] REQ_D = 2'd1;
  localparam logic [1:0] REQ_X = 2'd2;

  // qspi device-select codes
  localparam logic [1:0] MEM_FLASH  = 2'd0;
  localparam logic [1:0] MEM_PSRAM0 = 2'd1;
  localparam logic [1:0] MEM_PSRAM1 = 2'd2;

  // Device select for a transfer, from the ROM mapping mode and transfer attributes
  function automatic logic [1:0] mem_code(input logic [1:0] rom_mode,
                                          input logic       msb,
                                          input logic       i_d,
                                          input logic       write);
    logic [1:0] code;
    code = MEM_FLASH;
    case (rom_mode)
      2'b00:   code = msb ? MEM_PSRAM1 : MEM_FLASH;
      2'b01:   code = MEM_FLASH;
      2'b10:   code = msb ? MEM_PSRAM0 : MEM_FLASH;
      default: code = (i_d | ~write) ? MEM_PSRAM0 : MEM_FLASH;
    endcase
    return code;
  endfunction

  // Next requester in the i -> d -> x -> i rotation
  function automatic logic [1:0] next_idx(input logic [1:0] idx);
    return (idx == REQ_X) ? REQ_I : idx + 2'd1;
  endfunction

endpackage

// File: rtl/line_arb_rr_pick3.sv
// Combinational three-way round-robin picker with a d-follow override.
// Returns a one-hot winner (or zero when nobody requests).
module line_arb_rr_pick3
  import line_arb_pkg::*;
(
  input  logic [2:0] req,
  input  logic [1:0] rr_ptr,
  input  logic       d_follow,
  output logic [2:0] win
);

  logic [1:0] pos [3];

  // Requester index visited at each rotation offset, starting at rr_ptr
  assign pos[0] = rr_ptr;
  generate
    for (genvar gi = 1; gi < 3; gi++) begin : g_pos
      assign pos[gi] = next_idx(pos[gi-1]);
    end
  endgenerate

  // First requesting position in rotation order wins, unless a fill must follow a writeback
  always_comb begin
    win = 3'b000;
    if (d_follow && req[REQ_D]) begin
      win[REQ_D] = 1'b1;
    end else if (req[pos[0]]) begin
      win[pos[0]] = 1'b1;
    end else if (req[pos[1]]) begin
      win[pos[1]] = 1'b1;
    end else if (req[pos[2]]) begin
      win[pos[2]] = 1'b1;
    end
  end

endmodule

// File: rtl/line_arb.sv
// Owns the single qspi line-transfer engine and hands it to the icache,
// dcache or aux port in turn: grant, qspi request, wait for completion,
// then a one-cycle done pulse to the owner.
module line_arb
  import line_arb_pkg::*;
#(
  parameter  int PA          = 24,
  parameter  int LINE_LENGTH = 4,
  localparam int TW          = PA - $clog2(LINE_LENGTH)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [1:0]    rom_mode,
  input  logic          i_req,
  input  logic [TW-1:0] i_tag,
  output logic          i_done,
  input  logic          d_req,
  input  logic          d_write,
  input  logic [TW-1:0] d_tag,
  output logic          d_done,
  input  logic          x_req,
  input  logic          x_write,
  input  logic [TW-1:0] x_tag,
  output logic          x_done,
  output logic [2:0]    gnt,
  output logic          q_req,
  output logic          q_i_d,
  output logic          q_write,
  output logic [1:0]    q_mem,
  output logic [TW-1:0] q_paddr,
  input  logic          q_done
);

  state_t        state_reg;
  logic [1:0]    rr_ptr_reg;
  logic          d_follow_reg;

  logic [2:0]    req_vec;
  logic [2:0]    win;
  logic [1:0]    win_idx;
  logic [TW-1:0] sel_tag;
  logic          sel_write;
  logic [1:0]    sel_mem;

  assign req_vec = {x_req, d_req, i_req};

  line_arb_rr_pick3 u_pick (
    .req      (req_vec),
    .rr_ptr   (rr_ptr_reg),
    .d_follow (d_follow_reg),
    .win      (win)
  );

  // Steer the winner's tag and direction toward the qspi request registers
  always_comb begin
    sel_tag   = i_tag;
    sel_write = 1'b0;
    win_idx   = REQ_I;
    if (win[REQ_D]) begin
      sel_tag   = d_tag;
      sel_write = d_write;
      win_idx   = REQ_D;
    end else if (win[REQ_X]) begin
      sel_tag   = x_tag;
      sel_write = x_write;
      win_idx   = REQ_X;
    end
  end

  assign sel_mem = mem_code(rom_mode, sel_tag[TW-1], win[REQ_I], sel_write);

  // Transfer sequencer: latch a winner in IDLE, hold it through BUSY, pulse done on the way back
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg    <= ST_IDLE;
      gnt          <= 3'b000;
      q_req        <= 1'b0;
      q_i_d        <= 1'b0;
      q_write      <= 1'b0;
      q_mem        <= MEM_FLASH;
      q_paddr      <= '0;
      i_done       <= 1'b0;
      d_done       <= 1'b0;
      x_done       <= 1'b0;
      rr_ptr_reg   <= REQ_I;
      d_follow_reg <= 1'b0;
    end else begin
      i_done <= 1'b0;
      d_done <= 1'b0;
      x_done <= 1'b0;
      case (state_reg)
        ST_IDLE: begin
          if (|req_vec) begin
            state_reg    <= ST_BUSY;
            gnt          <= win;
            q_req        <= 1'b1;
            q_i_d        <= win[REQ_I];
            q_write      <= sel_write;
            q_mem        <= sel_mem;
            q_paddr      <= sel_tag;
            rr_ptr_reg   <= next_idx(win_idx);
            d_follow_reg <= 1'b0;
          end
        end
        ST_BUSY: begin
          if (q_done) begin
            state_reg <= ST_DONE;
            gnt       <= 3'b000;
            q_req     <= 1'b0;
            q_i_d     <= 1'b0;
            q_write   <= 1'b0;
            q_mem     <= MEM_FLASH;
            q_paddr   <= '0;
            i_done    <= gnt[REQ_I];
            d_done    <= gnt[REQ_D];
            x_done    <= gnt[REQ_X];
            // A completed writeback earns the dcache the next slot for its fill
            if (gnt[REQ_D] && q_write) begin
              d_follow_reg <= 1'b1;
            end
          end
        end
        ST_DONE: begin
          state_reg <= ST_IDLE;
        end
        default: begin
          state_reg <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_line_arb.sv
// Randomized scoreboard bench for line_arb: the stimulus side acts as the
// three requesters and the qspi engine and predicts each grant; a monitor
// pops predictions when a grant appears and checks done pulses.
module tb_line_arb;

  localparam int TW = 22;

  typedef struct {
    logic [2:0]    gnt;
    logic          wr;
    logic          idd;
    logic [1:0]    mem;
    logic [TW-1:0] tag;
    int            cyc;
    int            owner;
  } exp_t;

  logic          clk;
  logic          reset;
  logic [1:0]    rom_mode;
  logic          rq [3];
  logic          wr [3];
  logic [TW-1:0] tg [3];
  logic          q_done;
  logic          i_done, d_done, x_done;
  logic [2:0]    gnt;
  logic          q_req, q_i_d, q_write;
  logic [1:0]    q_mem;
  logic [TW-1:0] q_paddr;

  exp_t sb[$];
  int   errs = 0;
  int   checks = 0;
  int   cyc = 0;
  int   m_ptr = 0;
  bit   m_follow = 0;
  int   cur_owner = 0;
  bit   cur_wr = 0;

  line_arb #(.PA(24), .LINE_LENGTH(4)) dut (
    .clk(clk), .reset(reset), .rom_mode(rom_mode),
    .i_req(rq[0]), .i_tag(tg[0]), .i_done(i_done),
    .d_req(rq[1]), .d_write(wr[1]), .d_tag(tg[1]), .d_done(d_done),
    .x_req(rq[2]), .x_write(wr[2]), .x_tag(tg[2]), .x_done(x_done),
    .gnt(gnt), .q_req(q_req), .q_i_d(q_i_d), .q_write(q_write),
    .q_mem(q_mem), .q_paddr(q_paddr), .q_done(q_done)
  );

  initial clk = 0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input bit ok, input string name, input string detail);
    checks++;
    if (!ok) begin
      errs++;
      $display("FAIL %s: %s", name, detail);
    end
  endtask

  task automatic summary_and_finish();
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  endtask

  // Device select derived directly from the ROM mapping table
  function automatic logic [1:0] exp_mem(input logic [1:0] rm, input logic msb,
                                         input bit is_i, input bit w);
    case (rm)
      2'd0:    return msb ? 2'd2 : 2'd0;
      2'd1:    return 2'd0;
      2'd2:    return msb ? 2'd1 : 2'd0;
      default: return (is_i || !w) ? 2'd1 : 2'd0;
    endcase
  endfunction

  // Monitor: sample 1 time unit after each rising edge
  initial begin
    exp_t       cur;
    bit         busy_exp;
    logic [2:0] prev_gnt;
    logic [2:0] dv;
    logic [2:0] edv;
    busy_exp = 0;
    prev_gnt = 3'b000;
    cur = '{gnt: 3'b000, wr: 1'b0, idd: 1'b0, mem: 2'd0, tag: '0, cyc: 0, owner: 0};
    forever begin
      @(posedge clk);
      #1;
      if (reset) begin
        check({gnt, q_req, q_i_d, q_write, q_mem, q_paddr, i_done, d_done, x_done} == '0,
              "reset_outputs",
              $sformatf("gnt=%b q_req=%b q_i_d=%b q_write=%b q_mem=%0d q_paddr=%h done=%b%b%b, required all 0",
                        gnt, q_req, q_i_d, q_write, q_mem, q_paddr, x_done, d_done, i_done));
        busy_exp = 0;
        sb.delete();
        prev_gnt = 3'b000;
      end else begin
        dv  = {x_done, d_done, i_done};
        edv = (busy_exp && q_done) ? 3'(1 << cur.owner) : 3'b000;
        if (dv != 3'b000 || edv != 3'b000) begin
          check(dv == edv, "done_pulse",
                $sformatf("cycle %0d done{x,d,i}=%b, required %b", cyc, dv, edv));
          if (edv != 3'b000) begin
            check(gnt == 3'b000 && q_req == 1'b0, "release",
                  $sformatf("cycle %0d gnt=%b q_req=%b, required 000/0", cyc, gnt, q_req));
            busy_exp = 0;
          end
        end
        if (gnt != 3'b000)
          check($onehot(gnt), "gnt_onehot", $sformatf("cycle %0d gnt=%b, required one-hot", cyc, gnt));
        if (gnt != 3'b000 && prev_gnt == 3'b000) begin
          check(sb.size() != 0, "grant_expected",
                $sformatf("cycle %0d gnt=%b, required no grant", cyc, gnt));
          if (sb.size() != 0) begin
            cur = sb.pop_front();
            check(gnt == cur.gnt && q_req && q_write == cur.wr && q_i_d == cur.idd &&
                  q_mem == cur.mem && q_paddr == cur.tag, "grant_fields",
                  $sformatf("gnt=%b q_req=%b wr=%b i_d=%b mem=%0d tag=%h, required gnt=%b q_req=1 wr=%b i_d=%b mem=%0d tag=%h",
                            gnt, q_req, q_write, q_i_d, q_mem, q_paddr,
                            cur.gnt, cur.wr, cur.idd, cur.mem, cur.tag));
            check(cyc == cur.cyc, "grant_latency",
                  $sformatf("grant at cycle %0d, required %0d", cyc, cur.cyc));
            $display("xfer owner=%0d gnt=%b wr=%b mem=%0d tag=%h cycle=%0d",
                     cur.owner, gnt, q_write, q_mem, q_paddr, cyc);
            busy_exp = 1;
          end
        end else if (gnt != 3'b000 && busy_exp) begin
          check(gnt == cur.gnt && q_req && q_write == cur.wr && q_i_d == cur.idd &&
                q_mem == cur.mem && q_paddr == cur.tag, "busy_hold",
                $sformatf("cycle %0d gnt=%b wr=%b i_d=%b mem=%0d tag=%h, required %b %b %b %0d %h",
                          cyc, gnt, q_write, q_i_d, q_mem, q_paddr,
                          cur.gnt, cur.wr, cur.idd, cur.mem, cur.tag));
        end
        prev_gnt = gnt;
      end
    end
  end

  // Predict the next grant from the current requests, then wait for it to appear
  task automatic start_xfer(input int lat);
    exp_t e;
    int   w;
    bit   seen;
    w = -1;
    if (m_follow && rq[1]) w = 1;
    else begin
      for (int k = 0; k < 3; k++) begin
        int idx;
        idx = (m_ptr + k) % 3;
        if (w < 0 && rq[idx]) w = idx;
      end
    end
    if (w < 0) w = 0;
    e.owner = w;
    e.gnt   = 3'(1 << w);
    e.wr    = (w == 0) ? 1'b0 : wr[w];
    e.idd   = (w == 0);
    e.tag   = tg[w];
    e.mem   = exp_mem(rom_mode, tg[w][TW-1], w == 0, e.wr);
    e.cyc   = cyc + lat;
    sb.push_back(e);
    m_ptr     = (w + 1) % 3;
    m_follow  = 0;
    cur_owner = w;
    cur_wr    = e.wr;
    seen = 0;
    for (int t = 0; t < 10 && !seen; t++) begin
      @(negedge clk);
      seen = q_req;
    end
    if (!seen) begin
      check(1'b0, "grant_timeout", $sformatf("q_req=%b after 10 cycles, required 1", q_req));
      summary_and_finish();
    end
  endtask

  // Play the qspi engine: optional mid-transfer disturbance, then a one-cycle q_done
  task automatic finish_xfer(input int busy_len, input bit drop, input bit toggle);
    for (int t = 1; t < busy_len; t++) begin
      @(negedge clk);
      if (drop && t == 1) rq[cur_owner] = 1'b0;
      if (toggle) rom_mode = 2'($urandom);
    end
    @(negedge clk);
    q_done = 1'b1;
    @(negedge clk);
    q_done = 1'b0;
    if (cur_owner == 1 && cur_wr) m_follow = 1;
  endtask

  task automatic raise(input int i);
    rq[i] = 1'b1;
    wr[i] = 1'($urandom);
    tg[i] = TW'($urandom);
  endtask

  // New requests may only appear while nobody is waiting on them; losers hold
  task automatic rand_window(input int owner);
    for (int i = 0; i < 3; i++) begin
      if (i == owner) begin
        if ($urandom % 3 != 0) raise(i);
        else rq[i] = 1'b0;
      end else if (!rq[i] && ($urandom % 2 == 1)) begin
        raise(i);
      end
    end
    if (!(rq[0] | rq[1] | rq[2])) raise(int'($urandom % 3));
    rom_mode = 2'($urandom);
  endtask

  initial begin
    for (int i = 0; i < 3; i++) begin
      rq[i] = 1'b0;
      wr[i] = 1'b0;
      tg[i] = '0;
    end
    q_done = 1'b0;
    rom_mode = 2'd0;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    // Lone icache fill, ROM mode 00
    rq[0] = 1'b1;
    tg[0] = TW'(24'h001234 >> 2);
    start_xfer(1);
    finish_xfer(5, 0, 0);

    // dcache writeback to the upper half, then fill racing an icache request
    rq[0] = 1'b0;
    rq[1] = 1'b1; wr[1] = 1'b1; tg[1] = {1'b1, 21'($urandom)};
    start_xfer(2);
    finish_xfer(3, 0, 0);
    rq[1] = 1'b1; wr[1] = 1'b0; tg[1] = TW'($urandom);
    rq[0] = 1'b1; tg[0] = TW'($urandom);
    start_xfer(2);
    finish_xfer(2, 0, 0);
    rq[1] = 1'b0;
    start_xfer(2);
    finish_xfer(2, 0, 0);

    // All three held high for six transfers
    for (int i = 0; i < 3; i++) raise(i);
    rom_mode = 2'd0;
    repeat (6) begin
      start_xfer(2);
      finish_xfer(1 + int'($urandom % 3), 0, 0);
    end

    // ROM mode 11 device selection, with rom_mode churn during BUSY
    for (int i = 0; i < 3; i++) rq[i] = 1'b0;
    rq[2] = 1'b1; wr[2] = 1'b1; tg[2] = TW'($urandom); rom_mode = 2'd3;
    start_xfer(2);
    finish_xfer(2, 0, 0);
    wr[2] = 1'b0; rom_mode = 2'd3;
    start_xfer(2);
    finish_xfer(3, 0, 1);
    rq[2] = 1'b0; rq[0] = 1'b1; tg[0] = TW'($urandom); rom_mode = 2'd3;
    start_xfer(2);
    finish_xfer(4, 0, 1);

    // icache drops its request mid-transfer
    start_xfer(2);
    finish_xfer(4, 1, 0);

    // Random traffic
    repeat (40) begin
      rand_window(cur_owner);
      start_xfer(2);
      finish_xfer(1 + int'($urandom % 4), ($urandom % 4) == 0, 1'($urandom));
    end

    // Reset during BUSY, then a stray q_done while idle
    for (int i = 0; i < 3; i++) rq[i] = 1'b0;
    rq[1] = 1'b1; wr[1] = 1'b1; tg[1] = TW'($urandom);
    start_xfer(2);
    @(negedge clk);
    @(negedge clk);
    for (int i = 0; i < 3; i++) rq[i] = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    m_ptr = 0;
    m_follow = 0;
    repeat (3) @(negedge clk);
    q_done = 1'b1;
    @(negedge clk);
    q_done = 1'b0;
    repeat (3) @(negedge clk);

    // Traffic resumes after reset from a fresh round-robin pointer
    rand_window(-1);
    start_xfer(1);
    finish_xfer(2, 0, 0);
    repeat (10) begin
      rand_window(cur_owner);
      start_xfer(2);
      finish_xfer(1 + int'($urandom % 4), 0, 1'($urandom));
    end

    for (int i = 0; i < 3; i++) rq[i] = 1'b0;
    repeat (5) @(negedge clk);
    check(sb.size() == 0, "scoreboard_drained",
          $sformatf("%0d grants still predicted, required 0", sb.size()));
    summary_and_finish();
  end

endmodule
